// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic units (subtractor now, adder later).
package serial_arith_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  // Bit counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one bit per clock,
// framed by a start/busy/done handshake; results hold until the next operation.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] diff_reg;
  logic [WIDTH-1:0] diff_sh_next;
  logic [CW-1:0]    cnt_reg;
  logic             br_reg;
  logic             br_next;
  logic             d_bit;
  logic             bout_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             accept;
  logic             shift_en;

  assign accept   = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign shift_en = (state_reg == SHIFT);

  full_subtractor u_fs (
    .a    (a_sh_reg[0]),
    .b    (b_sh_reg[0]),
    .bin  (br_reg),
    .d    (d_bit),
    .bout (br_next)
  );

  // The bit shifted out of the partial result each cycle is never needed, so the
  // in-flight register only holds the upper WIDTH-1 result bits.
  generate
    if (WIDTH == 1) begin : g_w1
      assign diff_sh_next = d_bit;
    end else begin : g_wn
      logic [WIDTH-2:0] part_reg;

      assign diff_sh_next = {d_bit, part_reg};

      always_ff @(posedge clk) begin
        if (rst || accept) begin
          part_reg <= '0;
        end else if (shift_en) begin
          part_reg <= diff_sh_next[WIDTH-1:1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      cnt_reg   <= '0;
      br_reg    <= 1'b0;
      diff_reg  <= '0;
      bout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            cnt_reg   <= '0;
            br_reg    <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        SHIFT: begin
          a_sh_reg <= a_sh_reg >> 1;
          b_sh_reg <= b_sh_reg >> 1;
          br_reg   <= br_next;
          if (cnt_reg == LAST) begin
            diff_reg  <= diff_sh_next;
            bout_reg  <= br_next;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign diff = diff_reg;
  assign bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed table and corner sequences at WIDTH=8,
// plus randomized operations at WIDTH=1, 8 and 13 against an arithmetic model.
module tb_serial_subtractor;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts one operation at the current negedge and returns at the negedge where
  // done is seen (or the bound expires). Checks busy and the held previous result.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] ed,
                        input logic eb, input logic [7:0] held, input string name);
    int cyc;
    a = va;
    b = vb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    cyc = 1;
    while (!done && cyc <= 12) begin
      chk({name, " busy"}, busy, 1);
      chk({name, " diff held"}, diff, held);
      @(negedge clk);
      cyc++;
    end
    chk({name, " latency"}, cyc, 9);
    chk({name, " done"}, done, 1);
    chk({name, " busy at done"}, busy, 0);
    chk({name, " diff"}, diff, ed);
    chk({name, " bout"}, bout, eb);
    $display("[TB] %s: %02h - %02h -> diff=%02h bout=%0b (cycles %0d)", name, va, vb, diff, bout, cyc);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t vecs[8];

  // Randomized operation streams at several widths, each against plain a-b arithmetic.
  for (genvar gi = 0; gi < 3; gi++) begin : g_rand
    localparam int W = (gi == 0) ? 1 : (gi == 1) ? 8 : 13;
    logic         r_rst, r_start, r_busy, r_done, r_bout, fin;
    logic [W-1:0] r_a, r_b, r_diff;

    serial_subtractor #(.WIDTH(W)) u_dut (
      .clk   (clk),
      .rst   (r_rst),
      .start (r_start),
      .a     (r_a),
      .b     (r_b),
      .busy  (r_busy),
      .done  (r_done),
      .diff  (r_diff),
      .bout  (r_bout)
    );

    initial begin
      logic [W-1:0] ea, eb, ed;
      int cyc;
      int bad0;
      fin = 1'b0;
      r_rst = 1'b1;
      r_start = 1'b0;
      r_a = '0;
      r_b = '0;
      repeat (2) @(negedge clk);
      r_rst = 1'b0;
      @(negedge clk);
      bad0 = fails;
      for (int i = 0; i < 1000; i++) begin
        ea = W'($urandom);
        eb = W'($urandom);
        if (i == 0) begin ea = '0; eb = '1; end
        if (i == 1) begin ea = '1; eb = '0; end
        if (i == 2) eb = ea;
        r_a = ea;
        r_b = eb;
        r_start = 1'b1;
        @(negedge clk);
        r_start = 1'b0;
        cyc = 1;
        while (!r_done && cyc <= W + 4) begin
          chk($sformatf("w%0d busy", W), r_busy, 1);
          @(negedge clk);
          cyc++;
        end
        ed = ea - eb;
        chk($sformatf("w%0d latency", W), cyc, W + 1);
        chk($sformatf("w%0d diff %0h-%0h", W, ea, eb), r_diff, ed);
        chk($sformatf("w%0d bout %0h-%0h", W, ea, eb), r_bout, (ea < eb));
        if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      $display("[TB] width %0d: 1000 random operations, %0d new failures", W, fails - bad0);
      fin = 1'b1;
    end
  end

  initial begin
    logic [7:0] prev_d;
    int cyc;
    int npulse;
    int done_cyc;
    logic [7:0] done_diff;

    vecs[0] = '{8'h5A, 8'h23, 8'h37, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1};
    vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    vecs[3] = '{8'hAA, 8'hAA, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 8'h7F, 1'b0};
    vecs[6] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[7] = '{8'h03, 8'h05, 8'hFE, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset diff", diff, 0);
    chk("reset bout", bout, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle busy", busy, 0);
    chk("idle done", done, 0);

    // Directed table; odd entries follow the previous one back-to-back with no idle cycle.
    prev_d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, prev_d, $sformatf("vec%0d", i));
      prev_d = vecs[i].d;
      if (i % 2 == 1) begin
        @(negedge clk);
        chk("done one cycle", done, 0);
        chk("diff held idle", diff, prev_d);
        chk("bout held idle", bout, vecs[i].bo);
      end
    end

    // start during SHIFT must be ignored and produce only one done pulse.
    a = 8'h5A;
    b = 8'h23;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    npulse = 0;
    done_cyc = 0;
    done_diff = 8'h00;
    for (cyc = 1; cyc <= 14; cyc++) begin
      if (done) begin
        npulse++;
        done_cyc = cyc;
        done_diff = diff;
      end
      if (cyc == 3) begin
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("ignored start pulses", npulse, 1);
    chk("ignored start latency", done_cyc, 9);
    chk("ignored start diff", done_diff, 8'h37);
    chk("ignored start bout", bout, 0);
    $display("[TB] ignored-start: done pulses=%0d diff=%02h", npulse, done_diff);

    // Reset sampled on the fourth shift edge aborts the operation.
    a = 8'h80;
    b = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort diff", diff, 0);
    chk("abort bout", bout, 0);
    npulse = 0;
    repeat (12) begin
      if (done) npulse++;
      @(negedge clk);
    end
    chk("abort no done", npulse, 0);
    $display("[TB] abort: outputs cleared, done pulses after abort=%0d", npulse);
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 8'h00, "after abort");

    for (int k = 0; k < 60000 && !(g_rand[0].fin && g_rand[1].fin && g_rand[2].fin); k++)
      @(negedge clk);
    chk("random w1 finished", g_rand[0].fin, 1);
    chk("random w8 finished", g_rand[1].fin, 1);
    chk("random w13 finished", g_rand[2].fin, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
